control_sequencer: RTL and testbench

Multi-cycle control sequencer sitting between the instruction ID source and the combinational control decoder of the ARMAria core. It accepts one instruction ID per handshake and presents that ID to the decoder. It registers the decoder's control word and stretches it over the cycles the instruction needs: single-cycle ALU, memory or I/O read with wait, memory write with a one-cycle write strobe, or sticky halt. The datapath thus sees stable control signals while memory and I/O latency varies.

---
 rtl/control_sequencer_if.sv | 47 ++++
 rtl/control_sequencer.sv | 83 ++++++++
 tb/tb_control_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Handshake/decoder/datapath bundle for control_sequencer.
// The irq wire exists only when CONTROL_SEQ_IRQ_EN is defined.
interface control_sequencer_if #(
   parameter int ID_WIDTH   = 7,
   parameter int CTRL_WIDTH = 32
);
   logic [ID_WIDTH-1:0]   id;
   logic                  id_valid;
   logic                  id_ready;
   logic [ID_WIDTH-1:0]   decode_id;
   logic [CTRL_WIDTH-1:0] ctrl_in;
   logic                  is_load;
   logic                  is_store;
   logic                  is_halt;
   logic                  mem_done;
   logic [CTRL_WIDTH-1:0] ctrl_out;
   logic                  mem_write_strobe;
   logic                  reg_write;
   logic                  pc_enable;
   logic                  halted;
   logic                  timeout_err;
`ifdef CONTROL_SEQ_IRQ_EN
   logic                  irq;

   modport slave (
      input  id, id_valid, ctrl_in, is_load, is_store, is_halt, mem_done, irq,
      output id_ready, decode_id, ctrl_out, mem_write_strobe, reg_write,
             pc_enable, halted, timeout_err
   );
   modport master (
      output id, id_valid, ctrl_in, is_load, is_store, is_halt, mem_done, irq,
      input  id_ready, decode_id, ctrl_out, mem_write_strobe, reg_write,
             pc_enable, halted, timeout_err
   );
`else
   modport slave (
      input  id, id_valid, ctrl_in, is_load, is_store, is_halt, mem_done,
      output id_ready, decode_id, ctrl_out, mem_write_strobe, reg_write,
             pc_enable, halted, timeout_err
   );
   modport master (
      output id, id_valid, ctrl_in, is_load, is_store, is_halt, mem_done,
      input  id_ready, decode_id, ctrl_out, mem_write_strobe, reg_write,
             pc_enable, halted, timeout_err
   );
`endif
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: holds the decoder's control word across ALU, load/store waits and halt.
// Optional CONTROL_SEQ_IRQ_EN: irq injects the SWI ID (72) at IDLE / ALU-boundary accept points.
module control_sequencer #(
   parameter int ID_WIDTH    = 7,
   parameter int CTRL_WIDTH  = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input logic               clock,
   input logic               reset,
   control_sequencer_if.slave bus
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [ID_WIDTH-1:0] SWI_ID = ID_WIDTH'(72);

   typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT, HALT} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          load_q;
   logic          alu, open, irq_go, accept, done, abort;

   always_comb begin
      alu    = (state == EXEC) && !bus.is_halt && !bus.is_store && !bus.is_load;
      open   = (state == IDLE) || alu;
`ifdef CONTROL_SEQ_IRQ_EN
      irq_go = open && bus.irq;
`else
      irq_go = 1'b0;
`endif
      accept = open && !irq_go && bus.id_valid;
      // mem_done wins over a timeout landing in the same cycle
      done   = (state == MEM_WAIT) && bus.mem_done;
      abort  = (state == MEM_WAIT) && !bus.mem_done && (wait_cnt == CW'(MEM_TIMEOUT));
   end

   assign bus.id_ready         = open && !irq_go;
   assign bus.mem_write_strobe = (state == EXEC) && !bus.is_halt && bus.is_store;
   assign bus.reg_write        = alu || (done && load_q);
   assign bus.pc_enable        = alu || done || abort;
   assign bus.halted           = (state == HALT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         bus.decode_id   <= '0;
         bus.ctrl_out    <= '0;
         bus.timeout_err <= 1'b0;
         wait_cnt        <= '0;
         load_q          <= 1'b0;
      end else begin
         case (state)
            IDLE, EXEC: begin
               if (state == EXEC) begin
                  bus.ctrl_out <= bus.ctrl_in;
                  wait_cnt     <= '0;
                  // store outranks load, so a store never writes the register bank
                  load_q       <= bus.is_load && !bus.is_store;
               end
               if (state == EXEC && bus.is_halt)
                  state <= HALT;
               else if (state == EXEC && (bus.is_store || bus.is_load))
                  state <= MEM_WAIT;
               else if (irq_go) begin
                  bus.decode_id <= SWI_ID;
                  state         <= EXEC;
               end else if (accept) begin
                  bus.decode_id <= bus.id;
                  state         <= EXEC;
               end else
                  state <= IDLE;
            end
            MEM_WAIT: begin
               if (done || abort) begin
                  state <= IDLE;
                  if (abort) bus.timeout_err <= 1'b1;
               end else
                  wait_cnt <= wait_cnt + 1'b1;
            end
            default: state <= HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a small behavioural decoder model.
module tb_control_sequencer;
   localparam int IDW = 7;
   localparam int CWD = 32;

   logic clock = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   control_sequencer_if #(.ID_WIDTH(IDW), .CTRL_WIDTH(CWD)) bus ();

   control_sequencer #(.ID_WIDTH(IDW), .CTRL_WIDTH(CWD), .MEM_TIMEOUT(15)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ctrl_of(input logic [IDW-1:0] i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   // decoder model: 40-43 store, 44-47 load, 48 store+load, 75 halt, rest ALU
   always_comb begin
      bus.ctrl_in  = ctrl_of(bus.decode_id);
      bus.is_store = (bus.decode_id >= 7'd40 && bus.decode_id <= 7'd43) || bus.decode_id == 7'd48;
      bus.is_load  = (bus.decode_id >= 7'd44 && bus.decode_id <= 7'd47) || bus.decode_id == 7'd48;
      bus.is_halt  = (bus.decode_id == 7'd75);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset        = 1'b1;
      bus.id       = '0;
      bus.id_valid = 1'b0;
      bus.mem_done = 1'b0;
`ifdef CONTROL_SEQ_IRQ_EN
      bus.irq      = 1'b0;
`endif
      cyc(); cyc();
      reset = 1'b0;
      #1;
      check("rst_ready", bus.id_ready, 1);
      check("rst_decode", bus.decode_id, 0);
      check("rst_ctrl", bus.ctrl_out, 0);
      check("rst_tmo", bus.timeout_err, 0);
      check("rst_halt", bus.halted, 0);
      check("rst_strobes", {bus.reg_write, bus.pc_enable, bus.mem_write_strobe}, 0);

      // back-to-back ALU 4, 5, 12
      bus.id = 7'd4; bus.id_valid = 1'b1;
      cyc(); bus.id = 7'd5; #1;
      check("b2b_dec0", bus.decode_id, 4);
      check("b2b_rw0", {bus.reg_write, bus.pc_enable, bus.id_ready}, 3'b111);
      cyc(); bus.id = 7'd12; #1;
      check("b2b_dec1", bus.decode_id, 5);
      check("b2b_rw1", {bus.reg_write, bus.pc_enable}, 2'b11);
      check("b2b_ctrl1", bus.ctrl_out, ctrl_of(7'd4));
      cyc(); bus.id_valid = 1'b0; #1;
      check("b2b_dec2", bus.decode_id, 12);
      check("b2b_rw2", {bus.reg_write, bus.pc_enable}, 2'b11);
      check("b2b_ctrl2", bus.ctrl_out, ctrl_of(7'd5));
      cyc(); #1;
      check("b2b_idle", {bus.reg_write, bus.pc_enable, bus.id_ready}, 3'b001);
      check("b2b_ctrl3", bus.ctrl_out, ctrl_of(7'd12));

      // store 40, mem_done in third wait cycle
      bus.id = 7'd40; bus.id_valid = 1'b1;
      cyc(); bus.id_valid = 1'b0; #1;
      check("st_exec", {bus.mem_write_strobe, bus.reg_write, bus.pc_enable, bus.id_ready}, 4'b1000);
      for (int k = 1; k <= 3; k++) begin
         cyc();
         bus.mem_done = (k == 3);
         #1;
         check("st_wait", {bus.mem_write_strobe, bus.reg_write, bus.pc_enable}, {2'b00, k == 3});
      end
      check("st_ctrl", bus.ctrl_out, ctrl_of(7'd40));
      cyc(); bus.mem_done = 1'b0; #1;
      check("st_idle", {bus.pc_enable, bus.id_ready}, 2'b01);

      // ID 48 flags store and load: store wins, no register write at done
      bus.id = 7'd48; bus.id_valid = 1'b1;
      cyc(); bus.id_valid = 1'b0; #1;
      check("prio_strobe", bus.mem_write_strobe, 1);
      cyc(); bus.mem_done = 1'b1; #1;
      check("prio_done", {bus.reg_write, bus.pc_enable}, 2'b01);
      cyc(); bus.mem_done = 1'b0; #1;

      // load 44: mem_done in EXEC ignored, honoured in wait cycle 2
      bus.id = 7'd44; bus.id_valid = 1'b1;
      cyc(); bus.id_valid = 1'b0; bus.mem_done = 1'b1; #1;
      check("ld_exec", {bus.mem_write_strobe, bus.reg_write, bus.pc_enable, bus.id_ready}, 4'b0000);
      cyc(); bus.mem_done = 1'b0; #1;
      check("ld_w1", {bus.reg_write, bus.pc_enable}, 2'b00);
      cyc(); bus.mem_done = 1'b1; #1;
      check("ld_done", {bus.reg_write, bus.pc_enable}, 2'b11);
      cyc(); bus.mem_done = 1'b0; #1;
      check("ld_idle", {bus.reg_write, bus.id_ready}, 2'b01);
      check("ld_ctrl", bus.ctrl_out, ctrl_of(7'd44));

      // load 44 with no mem_done: abort in wait cycle 16
      bus.id = 7'd44; bus.id_valid = 1'b1;
      cyc(); bus.id_valid = 1'b0; #1;
      for (int k = 1; k <= 16; k++) begin
         cyc(); #1;
         check("tmo_wait", {bus.reg_write, bus.pc_enable, bus.timeout_err}, {1'b0, k == 16, 1'b0});
      end
      cyc(); #1;
      check("tmo_set", {bus.timeout_err, bus.id_ready, bus.pc_enable}, 3'b110);

      // reset while waiting (counter at 5)
      bus.id = 7'd44; bus.id_valid = 1'b1;
      cyc(); bus.id_valid = 1'b0;
      for (int k = 1; k <= 6; k++) cyc();
      check("mrst_wait", bus.id_ready, 0);
      reset = 1'b1; #1;
      check("mrst_ready", bus.id_ready, 1);
      check("mrst_ctrl", bus.ctrl_out, 0);
      check("mrst_tmo", bus.timeout_err, 0);
      cyc(); reset = 1'b0; #1;
      check("mrst_idle", {bus.id_ready, bus.pc_enable}, 2'b10);

      // halt 75, then hammer id_valid for 50 cycles
      bus.id = 7'd75; bus.id_valid = 1'b1;
      cyc(); bus.id = 7'd4; #1;
      check("hlt_exec", {bus.id_ready, bus.reg_write, bus.pc_enable, bus.mem_write_strobe}, 0);
      for (int k = 0; k < 50; k++) begin
         cyc(); #1;
         check("hlt_hold", {bus.halted, bus.id_ready, bus.pc_enable, bus.reg_write}, 4'b1000);
         check("hlt_dec", bus.decode_id, 75);
      end
      check("hlt_ctrl", bus.ctrl_out, ctrl_of(7'd75));
      bus.id_valid = 1'b0;
      reset = 1'b1; #1;
      check("hlt_rst", {bus.halted, bus.id_ready}, 2'b01);
      cyc(); reset = 1'b0; #1;

`ifdef CONTROL_SEQ_IRQ_EN
      // irq beats id_valid in IDLE; ID 4 accepted on the SWI's EXEC cycle
      bus.irq = 1'b1; bus.id = 7'd4; bus.id_valid = 1'b1; #1;
      check("irq_ready", bus.id_ready, 0);
      cyc(); bus.irq = 1'b0; #1;
      check("irq_dec", bus.decode_id, 72);
      check("irq_ready2", bus.id_ready, 1);
      cyc(); bus.id_valid = 1'b0; #1;
      check("irq_next", bus.decode_id, 4);
      cyc(); #1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
